// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: opcodes, R-type functs, loader instruction kinds and
// field positions. The control decoder and the instruction loader both use this.
package mips_isa_pkg;

  // Primary opcodes
  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  // Field LSB positions within the 32-bit instruction word
  localparam int unsigned OpLsb = 26;
  localparam int unsigned RsLsb = 21;
  localparam int unsigned RtLsb = 16;
  localparam int unsigned RdLsb = 11;

  // Abstract instruction kinds accepted by the loader; 11-15 are illegal
  typedef enum logic [3:0] {
    KindAdd  = 4'd0,
    KindSub  = 4'd1,
    KindAnd  = 4'd2,
    KindOr   = 4'd3,
    KindSlt  = 4'd4,
    KindLw   = 4'd5,
    KindSw   = 4'd6,
    KindBeq  = 4'd7,
    KindAddi = 4'd8,
    KindJ    = 4'd9,
    KindNop  = 4'd10
  } instr_kind_e;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return (32'(OpRType) << OpLsb) | (32'(rs) << RsLsb) | (32'(rt) << RtLsb) |
           (32'(rd) << RdLsb) | 32'(funct);
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return (32'(op) << OpLsb) | (32'(rs) << RsLsb) | (32'(rt) << RtLsb) | 32'(imm);
  endfunction

endpackage

// File: rtl/mips_instr_encode.sv
// Combinational encoder: instruction kind plus fields -> 32-bit MIPS word.
// Unused fields for a kind are ignored; kinds outside the table flag illegal.
module mips_instr_encode
  import mips_isa_pkg::*;
(
  input  logic [3:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  // Kind decode to instruction word
  always_comb begin
    word_o    = 32'h0;
    illegal_o = 1'b0;
    case (kind_i)
      KindAdd:  word_o = r_type(rs_i, rt_i, rd_i, FunctAdd);
      KindSub:  word_o = r_type(rs_i, rt_i, rd_i, FunctSub);
      KindAnd:  word_o = r_type(rs_i, rt_i, rd_i, FunctAnd);
      KindOr:   word_o = r_type(rs_i, rt_i, rd_i, FunctOr);
      KindSlt:  word_o = r_type(rs_i, rt_i, rd_i, FunctSlt);
      KindLw:   word_o = i_type(OpLw, rs_i, rt_i, imm_i);
      KindSw:   word_o = i_type(OpSw, rs_i, rt_i, imm_i);
      KindBeq:  word_o = i_type(OpBeq, rs_i, rt_i, imm_i);
      KindAddi: word_o = i_type(OpAddi, rs_i, rt_i, imm_i);
      KindJ:    word_o = {OpJ, target_i};
      KindNop:  word_o = 32'h0;
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_loader.sv
// Instruction loader: accepts abstract instruction beats over valid/ready, encodes
// them and writes the words to consecutive instruction-memory addresses starting
// at BASE_ADDR. One registered output stage; sustains one write per cycle.
module mips_instr_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              finish_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        in_kind_i,
  input  logic [4:0]        in_rs_i,
  input  logic [4:0]        in_rt_i,
  input  logic [4:0]        in_rd_i,
  input  logic [15:0]       in_imm_i,
  input  logic [25:0]       in_target_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Number of words that fit between BASE_ADDR and the top of memory
  localparam int unsigned   CapInt = (2 ** ADDR_W) - BASE_ADDR;
  localparam logic [ADDR_W:0]   Cap  = CapInt[ADDR_W:0];
  localparam logic [ADDR_W-1:0] Base = BASE_ADDR[ADDR_W-1:0];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        full;
  logic        accept;

  mips_instr_encode u_encode (
    .kind_i    (in_kind_i),
    .rs_i      (in_rs_i),
    .rt_i      (in_rt_i),
    .rd_i      (in_rd_i),
    .imm_i     (in_imm_i),
    .target_i  (in_target_i),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  // Ready depends only on state, count and start so it never loops through in_valid
  always_comb begin
    full       = (count_q == Cap);
    in_ready_o = (state_q == StLoad) && !start_i && !full;
    accept     = in_valid_i && in_ready_o;
  end

  // Next-state: beat acceptance, session start/finish
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    we_d    = 1'b0;

    if (accept) begin
      if (enc_illegal) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = enc_word;
        // ptr may roll over after the final slot, but full blocks any further use
        ptr_d   = ptr_q + 1'b1;
        count_d = count_q + 1'b1;
      end
    end

    if (start_i) begin
      state_d = StLoad;
      count_d = '0;
      err_d   = 1'b0;
      ptr_d   = Base;
    end else if (state_q == StLoad && finish_i) begin
      state_d = StDone;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      ptr_q   <= Base;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // Output mapping
  always_comb begin
    imem_we_o    = we_q;
    imem_addr_o  = addr_q;
    imem_wdata_o = wdata_q;
    count_o      = count_q;
    busy_o       = (state_q == StLoad);
    done_o       = (state_q == StDone);
    err_o        = err_q;
  end

endmodule

// File: tb/tb_mips_instr_loader.sv
// Self-checking bench for mips_instr_loader: directed vector table, corner-case
// sequences, and random stimulus against a session-level reference model.
module tb_mips_instr_loader;

  localparam int unsigned AW    = 8;
  localparam int unsigned BASE  = 0;
  localparam int          CAP   = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start, finish, in_valid;
  logic [3:0]  kind;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;

  logic          in_ready, imem_we, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;

  // Small instance for the full-memory corner: ADDR_W=2, BASE_ADDR=1
  logic        s_start, s_finish, s_valid;
  logic        s_ready, s_we, s_busy, s_done, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  mips_instr_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .finish_i     (finish),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_kind_i    (kind),
    .in_rs_i      (rs),
    .in_rt_i      (rt),
    .in_rd_i      (rd),
    .in_imm_i     (imm),
    .in_target_i  (target),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .count_o      (count),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  mips_instr_loader #(.ADDR_W(2), .BASE_ADDR(1)) dut_s (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (s_start),
    .finish_i     (s_finish),
    .in_valid_i   (s_valid),
    .in_ready_o   (s_ready),
    .in_kind_i    (kind),
    .in_rs_i      (rs),
    .in_rt_i      (rt),
    .in_rd_i      (rd),
    .in_imm_i     (imm),
    .in_target_i  (target),
    .imem_we_o    (s_we),
    .imem_addr_o  (s_addr),
    .imem_wdata_o (s_wdata),
    .count_o      (s_count),
    .busy_o       (s_busy),
    .done_o       (s_done),
    .err_o        (s_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: session state (0 idle, 1 load, 2 done), words written, sticky err,
  // last write strobe and the held address/data.
  int          m_st, m_cnt;
  logic        m_err, m_we;
  logic [31:0] m_addr, m_data;

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_err = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_data = 32'h0;
  endtask

  // Encoding straight from the ISA tables: returns {illegal, word}
  function automatic logic [32:0] ref_enc(input logic [3:0] k, input logic [4:0] a,
                                          input logic [4:0] b, input logic [4:0] c,
                                          input logic [15:0] im, input logic [25:0] tg);
    logic [31:0] w;
    logic [5:0]  f, op;
    f = 6'd0; op = 6'd0; w = 32'h0;
    case (k)
      4'd0: f = 6'd32;
      4'd1: f = 6'd34;
      4'd2: f = 6'd36;
      4'd3: f = 6'd37;
      4'd4: f = 6'd42;
      4'd5: op = 6'd35;
      4'd6: op = 6'd43;
      4'd7: op = 6'd4;
      4'd8: op = 6'd8;
      4'd9: op = 6'd2;
      default: ;
    endcase
    if (k <= 4'd4)      w = (32'(a) << 21) | (32'(b) << 16) | (32'(c) << 11) | 32'(f);
    else if (k <= 4'd8) w = (32'(op) << 26) | (32'(a) << 21) | (32'(b) << 16) | 32'(im);
    else if (k == 4'd9) w = (32'(op) << 26) | 32'(tg);
    return {k > 4'd10, w};
  endfunction

  // One clock: check ready, advance the model, check registered outputs after the edge
  task automatic step();
    logic        rdy;
    logic [32:0] e;
    #1;
    rdy = (m_st == 1) && !start && (m_cnt < CAP);
    chk("in_ready", in_ready, rdy);
    m_we = 1'b0;
    if (in_valid && rdy) begin
      e = ref_enc(kind, rs, rt, rd, imm, target);
      if (e[32]) m_err = 1'b1;
      else begin
        m_we = 1'b1; m_addr = 32'(BASE + m_cnt); m_data = e[31:0]; m_cnt++;
      end
    end
    if (start) begin
      m_st = 1; m_cnt = 0; m_err = 1'b0;
    end else if (m_st == 1 && finish) begin
      m_st = 2;
    end
    @(posedge clk);
    #1;
    chk("imem_we", imem_we, m_we);
    chk("imem_addr", imem_addr, m_addr);
    chk("imem_wdata", imem_wdata, m_data);
    chk("count", count, 32'(m_cnt));
    chk("busy", busy, m_st == 1);
    chk("done", done, m_st == 2);
    chk("err", err, m_err);
  endtask

  task automatic set_fields(input logic [3:0] k, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input logic [15:0] im,
                            input logic [25:0] tg);
    kind = k; rs = a; rt = b; rd = c; imm = im; target = tg;
  endtask

  task automatic idle();
    start = 1'b0; finish = 1'b0; in_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  k;
    logic [4:0]  a, b, c;
    logic [15:0] im;
    logic [25:0] tg;
    logic [31:0] word;
    logic        ill;
  } vec_t;

  vec_t tbl[14];
  int   n_wr;

  initial begin
    tbl[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'h1234, 26'h3FFFFFF, 32'h00221820, 1'b0};
    tbl[1]  = '{4'd5,  5'd29, 5'd8,  5'd7,  16'h0004, 26'h0,       32'h8FA80004, 1'b0};
    tbl[2]  = '{4'd6,  5'd29, 5'd9,  5'd0,  16'h0008, 26'h0,       32'hAFA90008, 1'b0};
    tbl[3]  = '{4'd9,  5'd5,  5'd6,  5'd7,  16'hFFFF, 26'h0000010, 32'h08000010, 1'b0};
    tbl[4]  = '{4'd8,  5'd0,  5'd1,  5'd31, 16'h0005, 26'h0,       32'h20010005, 1'b0};
    tbl[5]  = '{4'd12, 5'd1,  5'd1,  5'd1,  16'h0001, 26'h1,       32'h0,        1'b1};
    tbl[6]  = '{4'd8,  5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       32'h2022FFFF, 1'b0};
    tbl[7]  = '{4'd1,  5'd4,  5'd5,  5'd6,  16'hABCD, 26'h0,       32'h00853022, 1'b0};
    tbl[8]  = '{4'd2,  5'd7,  5'd8,  5'd9,  16'h0,    26'h0,       32'h00E84824, 1'b0};
    tbl[9]  = '{4'd3,  5'd31, 5'd31, 5'd31, 16'h0,    26'h0,       32'h03FFF825, 1'b0};
    tbl[10] = '{4'd4,  5'd1,  5'd2,  5'd3,  16'h0,    26'h0,       32'h0022182A, 1'b0};
    tbl[11] = '{4'd7,  5'd1,  5'd2,  5'd0,  16'h0003, 26'h0,       32'h10220003, 1'b0};
    tbl[12] = '{4'd10, 5'd9,  5'd9,  5'd9,  16'h5555, 26'h2AAAAAA, 32'h00000000, 1'b0};
    tbl[13] = '{4'd15, 5'd0,  5'd0,  5'd0,  16'h0,    26'h0,       32'h0,        1'b1};

    idle();
    s_start = 1'b0; s_finish = 1'b0; s_valid = 1'b0;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    model_reset();

    // Reset values
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_s_count", s_count, 0);
    #10 rst_n = 1'b1;

    // Vector table streamed back-to-back
    start = 1'b1; step(); start = 1'b0;
    n_wr = 0;
    foreach (tbl[i]) begin
      set_fields(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].im, tbl[i].tg);
      in_valid = 1'b1;
      step();
      chk("tbl_we", imem_we, !tbl[i].ill);
      if (!tbl[i].ill) begin
        chk("tbl_word", imem_wdata, tbl[i].word);
        chk("tbl_addr", imem_addr, 32'(n_wr));
        n_wr++;
      end
    end
    idle(); step();
    chk("tbl_count", count, 12);
    chk("tbl_err", err, 1);

    // Illegal kind between two ADDIs; next start clears err
    start = 1'b1; step(); start = 1'b0; in_valid = 1'b1;
    set_fields(4'd8, 5'd0, 5'd1, 5'd0, 16'h0007, 26'h0); step();
    set_fields(4'd12, 5'd0, 5'd1, 5'd0, 16'h0007, 26'h0); step();
    set_fields(4'd8, 5'd2, 5'd3, 5'd0, 16'h0009, 26'h0); step();
    idle(); step();
    chk("ill_count", count, 2);
    chk("ill_err", err, 1);
    chk("ill_last_addr", imem_addr, 1);
    start = 1'b1; step(); start = 1'b0;
    chk("ill_err_cleared", err, 0);
    chk("ill_count_cleared", count, 0);

    // BEQ accepted together with finish: write lands in the first DONE cycle
    set_fields(4'd7, 5'd1, 5'd2, 5'd0, 16'h0003, 26'h0);
    in_valid = 1'b1; finish = 1'b1; step();
    chk("beq_done", done, 1);
    chk("beq_we", imem_we, 1);
    chk("beq_word", imem_wdata, 32'h10220003);
    idle(); step();
    chk("beq_ready_after", in_ready, 0);
    chk("beq_we_after", imem_we, 0);

    // Full memory on ADDR_W=2, BASE_ADDR=1: three slots (addresses 1..3)
    s_start = 1'b1; step(); s_start = 1'b0;
    set_fields(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    s_valid = 1'b1;
    #1 chk("s_ready_empty", s_ready, 1);
    step();
    chk("s_first_we", s_we, 1);
    chk("s_first_addr", s_addr, 1);
    chk("s_first_count", s_count, 1);
    step(); step();
    chk("s_third_addr", s_addr, 3);
    chk("s_third_word", s_wdata, 32'h00221820);
    chk("s_full_count", s_count, 3);
    #1 chk("s_full_ready", s_ready, 0);
    step();
    chk("s_held_we", s_we, 0);
    chk("s_held_count", s_count, 3);
    chk("s_held_busy", s_busy, 1);
    s_valid = 1'b0; s_finish = 1'b1; step(); s_finish = 1'b0;
    chk("s_done", s_done, 1);
    chk("s_busy_after", s_busy, 0);
    chk("s_err", s_err, 0);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      start    = (i == 0) || ($urandom_range(0, 99) < 3);
      finish   = ($urandom_range(0, 99) < 3);
      in_valid = ($urandom_range(0, 99) < 70);
      set_fields(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
                 16'($urandom), 26'($urandom));
      step();
    end

    // Asynchronous reset in the middle of a streaming session
    idle(); start = 1'b1; step(); start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_fields(4'd0, 5'(i), 5'(i + 1), 5'(i + 2), 16'h0, 26'h0);
      step();
    end
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", imem_we, 0);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_wdata", imem_wdata, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_ready", in_ready, 0);
    model_reset();
    #2 rst_n = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    set_fields(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    in_valid = 1'b1; step();
    chk("resume_addr", imem_addr, BASE);
    chk("resume_word", imem_wdata, 32'h00221820);
    idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
